btn_conditioner: RTL



---
 rtl/btn_pkg.sv | 14 +
 rtl/btn_debounce_channel.sv | 52 +++++
 rtl/btn_conditioner.sv | 31 +++
 3 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: channel indices, board/simulation timing defaults and counter sizing helper.
package btn_pkg;
  localparam int BTN_LOAD_X   = 0;
  localparam int BTN_LOAD_Y   = 1;
  localparam int BTN_START    = 2;
  localparam int BTN_TOGGLE_K = 3;
  localparam int DEB_DEFAULT  = 1_000_000;
  localparam int LONG_DEFAULT = 100_000_000;
  localparam int DEB_SIM      = 4;
  localparam int LONG_SIM     = 10;
  function automatic int cnt_width(input int d, input int l);
    return $clog2((d > l ? d : l) + 1);
  endfunction
endpackage

// File: rtl/btn_debounce_channel.sv
// btn_debounce_channel: one button's synchroniser, debounce, level/press/release/long-press flops.
module btn_debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEB_DEFAULT,
  parameter int LONG_CYCLES     = LONG_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic pulse,
  output logic rel,
  output logic long_press
);
  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  logic s1, s2, long_done, accept, expire;
  logic [CNT_W-1:0] deb_cnt, hold_cnt;
  always_comb begin
    accept = (s2 != level) && (deb_cnt == DEB_LAST);
    expire = level && !long_done && (hold_cnt == LONG_LAST);
  end
  // an accepted release on the expiry cycle suppresses the long pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      level      <= 1'b0;
      deb_cnt    <= '0;
      hold_cnt   <= '0;
      long_done  <= 1'b0;
      pulse      <= 1'b0;
      rel        <= 1'b0;
      long_press <= 1'b0;
    end else begin
      s1         <= raw;
      s2         <= s1;
      deb_cnt    <= (s2 == level || accept) ? '0 : deb_cnt + 1'b1;
      level      <= accept ? s2 : level;
      pulse      <= accept & s2;
      rel        <= accept & ~s2;
      long_press <= expire & ~accept;
      if (!level) begin
        hold_cnt  <= '0;
        long_done <= 1'b0;
      end else if (expire) long_done <= ~accept;
      else if (!long_done) hold_cnt <= hold_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/btn_conditioner.sv
// btn_conditioner: N_BTN independent debounced button channels feeding the classifier's btn_* inputs.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = DEB_DEFAULT,
  parameter int LONG_CYCLES     = LONG_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .raw(btn_raw[i]),
      .level(btn_level[i]),
      .pulse(btn_pulse[i]),
      .rel(btn_release[i]),
      .long_press(btn_long[i])
    );
  end
endmodule
